// File: rtl/deser_pkg.sv
// Shared types and helpers for the stream deserializer.
package deser_pkg;

  // Accumulator states: empty, partially filled, complete but waiting for the output slot.
  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_FILL = 2'd1,
    ACC_FULL = 2'd2
  } acc_state_e;

  // Width needed to hold a lane count from 0 up to parl_max inclusive.
  function automatic int cnt_w(input int parl_max);
    return $clog2(parl_max + 1);
  endfunction

  // Lane that beat k of a word lands in, for the given ratio and direction.
  function automatic int lane_idx(input int k, input int ratio, input logic dir);
    int idx;
    if (dir) begin
      idx = ratio - 1 - k;
    end else begin
      idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/deserializer_stream_if.sv
// Serial-in / parallel-out stream bundle for the deserializer.
// master drives beats and consumes words; slave is the deserializer side.
interface deserializer_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PARL_MAX   = 8
) ();
  import deser_pkg::*;

  localparam int CNT_W = cnt_w(PARL_MAX);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data [PARL_MAX];
  logic [CNT_W-1:0]      m_count;
  logic                  m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count, m_last
  );

endinterface

// File: rtl/deser_out_slot.sv
// One-entry output register: loads a finished word, holds it until consumed.
module deser_out_slot
  import deser_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  PARL_MAX   = 8,
  localparam int CNT_W      = cnt_w(PARL_MAX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i [PARL_MAX],
  input  logic [CNT_W-1:0]      load_count_i,
  input  logic                  load_last_i,
  input  logic                  m_ready_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o [PARL_MAX],
  output logic [CNT_W-1:0]      m_count_o,
  output logic                  m_last_o,
  output logic                  free_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q [PARL_MAX];
  logic [CNT_W-1:0]      count_q;
  logic                  last_q;

  // The slot can take a new word when empty or when its word leaves this cycle.
  assign free_o    = !valid_q || m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_count_o = count_q;
  assign m_last_o  = last_q;

  // Slot register: load wins over drain; payload only changes on load so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      count_q <= {CNT_W{1'b0}};
      last_q  <= 1'b0;
      for (int l = 0; l < PARL_MAX; l++) begin
        data_q[l] <= {DATA_WIDTH{1'b0}};
      end
    end else if (load_i) begin
      valid_q <= 1'b1;
      count_q <= load_count_i;
      last_q  <= load_last_i;
      data_q  <= load_data_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

endmodule

// File: rtl/deserializer_stream.sv
// Stream deserializer: packs DATA_WIDTH beats into words of up to PARL_MAX lanes
// with a runtime ratio and lane direction; s_last closes a zero-padded partial word.
module deserializer_stream
  import deser_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  PARL_MAX   = 8,
  localparam int CNT_W      = cnt_w(PARL_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_ratio,
  input  logic             cfg_dir,
  output logic             err_cfg,
  deserializer_stream_if.slave bus
);

  localparam logic [CNT_W-1:0] RATIO_MAX = CNT_W'(PARL_MAX);

  logic                  rst_q;
  acc_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      ratio_q, ratio_d;
  logic                  dir_q, dir_d;
  logic [DATA_WIDTH-1:0] acc_q [PARL_MAX];
  logic [DATA_WIDTH-1:0] acc_d [PARL_MAX];
  logic [CNT_W-1:0]      acc_count_q, acc_count_d;
  logic                  acc_last_q, acc_last_d;
  logic                  err_q, err_d;

  logic                  s_ready_s;
  logic                  fire_s;
  logic                  first_s;
  logic                  illegal_s;
  logic [CNT_W-1:0]      eff_ratio_s;
  logic                  eff_dir_s;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic                  done_s;
  int                    lane_s;
  logic [DATA_WIDTH-1:0] word_s [PARL_MAX];

  logic                  slot_free_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] load_data_s [PARL_MAX];
  logic [CNT_W-1:0]      load_count_s;
  logic                  load_last_s;

  logic                  slot_valid_s;
  logic [DATA_WIDTH-1:0] slot_data_s [PARL_MAX];
  logic [CNT_W-1:0]      slot_count_s;
  logic                  slot_last_s;

  // Ready depends only on registered state, never on m_ready.
  assign s_ready_s = !rst_q && (state_q != ACC_FULL);
  assign fire_s    = bus.s_valid && s_ready_s;

  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = slot_valid_s;
  assign bus.m_data  = slot_data_s;
  assign bus.m_count = slot_count_s;
  assign bus.m_last  = slot_last_s;
  assign err_cfg     = err_q;

  // Beat path: pick the ratio/direction in force for this beat and build the updated word.
  always_comb begin
    first_s   = (state_q == ACC_IDLE);
    illegal_s = (cfg_ratio == {CNT_W{1'b0}}) || (cfg_ratio > RATIO_MAX);
    if (first_s) begin
      eff_ratio_s = illegal_s ? RATIO_MAX : cfg_ratio;
      eff_dir_s   = cfg_dir;
    end else begin
      eff_ratio_s = ratio_q;
      eff_dir_s   = dir_q;
    end
    cnt_inc_s = cnt_q + CNT_W'(1);
    done_s    = (cnt_inc_s == eff_ratio_s) || bus.s_last;
    lane_s    = lane_idx(int'(cnt_q), int'(eff_ratio_s), eff_dir_s);
    for (int l = 0; l < PARL_MAX; l++) begin
      if (l == lane_s) begin
        word_s[l] = bus.s_data;
      end else begin
        word_s[l] = first_s ? {DATA_WIDTH{1'b0}} : acc_q[l];
      end
    end
  end

  // Accumulator next state and hand-off of finished words into the output slot.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ratio_d      = ratio_q;
    dir_d        = dir_q;
    acc_d        = acc_q;
    acc_count_d  = acc_count_q;
    acc_last_d   = acc_last_q;
    err_d        = 1'b0;
    load_s       = 1'b0;
    load_data_s  = acc_q;
    load_count_s = acc_count_q;
    load_last_s  = acc_last_q;
    case (state_q)
      ACC_IDLE, ACC_FILL: begin
        if (fire_s) begin
          if (first_s) begin
            ratio_d = eff_ratio_s;
            dir_d   = cfg_dir;
            err_d   = illegal_s;
          end else begin
            ratio_d = ratio_q;
          end
          if (done_s) begin
            if (slot_free_s) begin
              load_s       = 1'b1;
              load_data_s  = word_s;
              load_count_s = cnt_inc_s;
              load_last_s  = bus.s_last;
              state_d      = ACC_IDLE;
              cnt_d        = {CNT_W{1'b0}};
              for (int l = 0; l < PARL_MAX; l++) begin
                acc_d[l] = {DATA_WIDTH{1'b0}};
              end
            end else begin
              state_d     = ACC_FULL;
              acc_d       = word_s;
              acc_count_d = cnt_inc_s;
              acc_last_d  = bus.s_last;
              cnt_d       = {CNT_W{1'b0}};
            end
          end else begin
            state_d = ACC_FILL;
            cnt_d   = cnt_inc_s;
            acc_d   = word_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      ACC_FULL: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          state_d     = ACC_IDLE;
          acc_count_d = {CNT_W{1'b0}};
          acc_last_d  = 1'b0;
          for (int l = 0; l < PARL_MAX; l++) begin
            acc_d[l] = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = ACC_FULL;
        end
      end
      default: begin
        state_d = ACC_IDLE;
      end
    endcase
  end

  // State register; reset drops any partial word and keeps ready low for one extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q       <= 1'b1;
      state_q     <= ACC_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      ratio_q     <= {CNT_W{1'b0}};
      dir_q       <= 1'b0;
      acc_count_q <= {CNT_W{1'b0}};
      acc_last_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int l = 0; l < PARL_MAX; l++) begin
        acc_q[l] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      rst_q       <= 1'b0;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      dir_q       <= dir_d;
      acc_count_q <= acc_count_d;
      acc_last_q  <= acc_last_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
    end
  end

  deser_out_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARL_MAX   (PARL_MAX)
  ) u_slot (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_s),
    .load_data_i  (load_data_s),
    .load_count_i (load_count_s),
    .load_last_i  (load_last_s),
    .m_ready_i    (bus.m_ready),
    .m_valid_o    (slot_valid_s),
    .m_data_o     (slot_data_s),
    .m_count_o    (slot_count_s),
    .m_last_o     (slot_last_s),
    .free_o       (slot_free_s)
  );

endmodule

// File: tb/tb_deserializer_stream.sv
// Self-checking bench for deserializer_stream: directed beats plus a queue-based word model.
module tb_deserializer_stream;
  import deser_pkg::*;

  localparam int DW = 8;
  localparam int PM = 8;
  localparam int CW = cnt_w(PM);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_ratio;
  logic          cfg_dir;
  logic          err_cfg;

  deserializer_stream_if #(.DATA_WIDTH(DW), .PARL_MAX(PM)) bus ();

  deserializer_stream #(.DATA_WIDTH(DW), .PARL_MAX(PM)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_ratio (cfg_ratio),
    .cfg_dir   (cfg_dir),
    .err_cfg   (err_cfg),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected word: lane i in bits [8i+:8].
  typedef struct {
    logic [63:0] data;
    int          count;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] cur [PM];
  int         cur_n = 0;
  int         mr = PM;
  logic       md = 1'b0;
  logic       err_pend = 1'b0;

  function automatic logic [63:0] pack_m();
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < PM; i++) v[8*i +: 8] = bus.m_data[i];
    return v;
  endfunction

  // Model + compare, sampled on the falling edge; handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    word_t w;
    int    r;
    int    lane;
    if (rst) begin
      cur_n = 0;
      exp_q.delete();
      err_pend = 1'b0;
    end else begin
      chk("m_valid", 64'(bus.m_valid), 64'(exp_q.size() != 0));
      if (bus.m_valid && exp_q.size() != 0) begin
        chk("m_data", pack_m(), exp_q[0].data);
        chk("m_count", 64'(bus.m_count), 64'(exp_q[0].count));
        chk("m_last", 64'(bus.m_last), 64'(exp_q[0].last));
        if (bus.m_ready) void'(exp_q.pop_front());
      end
      chk("err_cfg", 64'(err_cfg), 64'(err_pend));
      err_pend = 1'b0;
      if (bus.s_valid && bus.s_ready) begin
        if (cur_n == 0) begin
          r = int'(cfg_ratio);
          if (r == 0 || r > PM) begin
            r = PM;
            err_pend = 1'b1;
          end
          mr = r;
          md = cfg_dir;
        end
        cur[cur_n] = bus.s_data;
        cur_n++;
        if (cur_n == mr || bus.s_last) begin
          w.data = 64'd0;
          for (int k = 0; k < cur_n; k++) begin
            lane = md ? (mr - 1 - k) : k;
            w.data[8*lane +: 8] = cur[k];
          end
          w.count = cur_n;
          w.last  = bus.s_last;
          exp_q.push_back(w);
          cur_n = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until accepted; returns the number of cycles it took.
  task automatic send(input logic [7:0] d, input logic last, output int cyc);
    logic acc;
    cyc = 0;
    acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    do begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!acc && cyc < 100);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("send_accept", 64'(acc), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int c;
    int tot;
    int idx;
    logic acc;
    logic [7:0] b [6];

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    cfg_ratio   = CW'(4);
    cfg_dir     = 1'b0;

    // Reset state
    step();
    @(negedge clk);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_m_count", 64'(bus.m_count), 64'd0);
    chk("rst_m_last", 64'(bus.m_last), 64'd0);
    chk("rst_err", 64'(err_cfg), 64'd0);
    chk("rst_m_data", pack_m(), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_lag", 64'(bus.s_ready), 64'd0);
    step();
    @(negedge clk);
    chk("s_ready_up", 64'(bus.s_ready), 64'd1);
    step();

    // ratio 4, dir 0, back-to-back
    tot = 0;
    send(8'h11, 1'b0, c); tot += c;
    send(8'h22, 1'b0, c); tot += c;
    send(8'h33, 1'b0, c); tot += c;
    send(8'h44, 1'b0, c); tot += c;
    chk("tput_r4", 64'(tot), 64'd4);
    @(negedge clk);
    chk("t1_valid", 64'(bus.m_valid), 64'd1);
    chk("t1_data", pack_m(), 64'h0000_0000_4433_2211);
    chk("t1_count", 64'(bus.m_count), 64'd4);
    chk("t1_last", 64'(bus.m_last), 64'd0);
    step();

    // ratio 4, dir 1
    cfg_dir = 1'b1;
    send(8'h11, 1'b0, c);
    send(8'h22, 1'b0, c);
    send(8'h33, 1'b0, c);
    send(8'h44, 1'b0, c);
    @(negedge clk);
    chk("t2_data", pack_m(), 64'h0000_0000_1122_3344);
    chk("t2_count", 64'(bus.m_count), 64'd4);
    step();

    // early s_last: partial word
    cfg_dir = 1'b0;
    send(8'hA1, 1'b0, c);
    send(8'hA2, 1'b1, c);
    @(negedge clk);
    chk("t3_data", pack_m(), 64'h0000_0000_0000_A2A1);
    chk("t3_count", 64'(bus.m_count), 64'd2);
    chk("t3_last", 64'(bus.m_last), 64'd1);
    step();

    // ratio 3 streaming, 9 beats with no bubbles
    cfg_ratio = CW'(3);
    tot = 0;
    for (int i = 0; i < 9; i++) begin
      send(8'(8'h50 + i), 1'b0, c);
      tot += c;
    end
    chk("tput_r3", 64'(tot), 64'd9);
    step();

    // ratio 1: every beat is a word
    cfg_ratio = CW'(1);
    send(8'h9A, 1'b0, c);
    @(negedge clk);
    chk("r1_data", pack_m(), 64'h0000_0000_0000_009A);
    chk("r1_count", 64'(bus.m_count), 64'd1);
    step();

    // back-pressure: ratio 2, m_ready low for 10 cycles, 6 beats offered
    cfg_ratio = CW'(2);
    bus.m_ready = 1'b0;
    b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = (idx < 6);
      bus.s_data  = b[idx < 6 ? idx : 5];
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    bus.s_valid = 1'b0;
    chk("bp_accepted", 64'(idx), 64'd4);
    @(negedge clk);
    chk("bp_s_ready", 64'(bus.s_ready), 64'd0);
    chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
    chk("bp_data", pack_m(), 64'h0000_0000_0000_C1C0);
    step();
    bus.m_ready = 1'b1;
    send(b[4], 1'b0, c);
    send(b[5], 1'b0, c);
    repeat (3) step();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // illegal ratio 0 -> 8 lanes; mid-word cfg change ignored
    cfg_ratio = CW'(0);
    cfg_dir   = 1'b0;
    send(8'h01, 1'b0, c);
    cfg_ratio = CW'(4);
    @(negedge clk);
    chk("err0_pulse", 64'(err_cfg), 64'd1);
    step();
    for (int i = 2; i <= 8; i++) send(8'(i), 1'b0, c);
    @(negedge clk);
    chk("err0_data", pack_m(), 64'h0807_0605_0403_0201);
    chk("err0_count", 64'(bus.m_count), 64'd8);
    chk("err0_clear", 64'(err_cfg), 64'd0);
    step();

    // illegal ratio 9, dir 1
    cfg_ratio = CW'(9);
    cfg_dir   = 1'b1;
    send(8'h10, 1'b0, c);
    cfg_ratio = CW'(2);
    @(negedge clk);
    chk("err9_pulse", 64'(err_cfg), 64'd1);
    step();
    for (int i = 1; i < 8; i++) send(8'(8'h10 + i), 1'b0, c);
    @(negedge clk);
    chk("err9_data", pack_m(), 64'h1011_1213_1415_1617);
    chk("err9_count", 64'(bus.m_count), 64'd8);
    step();

    // reset mid-word discards the partial word
    cfg_ratio = CW'(4);
    cfg_dir   = 1'b0;
    send(8'h31, 1'b0, c);
    send(8'h32, 1'b0, c);
    send(8'h33, 1'b0, c);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mrst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("mrst_m_valid", 64'(bus.m_valid), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_no_word", 64'(bus.m_valid), 64'd0);
    step();
    send(8'h41, 1'b0, c);
    send(8'h42, 1'b0, c);
    send(8'h43, 1'b0, c);
    send(8'h44, 1'b0, c);
    @(negedge clk);
    chk("mrst_data", pack_m(), 64'h0000_0000_4443_4241);
    chk("mrst_count", 64'(bus.m_count), 64'd4);
    step();

    repeat (5) step();
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deserializer_stream.md
Name: deserializer_stream

Overview:
- Multi-bit stream deserializer with valid/ready on both sides. Replaces the free-running enable-driven deserializer on the FFT input path.
- Collects DATA_WIDTH beats into a word of up to PARL_MAX lanes. Ratio and lane direction are runtime-configurable; early s_last closes a word as a zero-padded partial word.
- A two-stage structure (accumulator + output slot) sustains one beat per cycle under back-pressure.

Parameters:
- DATA_WIDTH, 8, width of one serial beat and of one parallel lane
- PARL_MAX, 8, maximum lanes per word (>=2); CNT_W = $clog2(PARL_MAX+1) is derived as a localparam

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_ratio  in  CNT_W  beats per word, valid 1..PARL_MAX
- cfg_dir  in  1  0: first beat to lane 0; 1: first beat to lane ratio-1
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid&s_ready
- s_data  in  DATA_WIDTH  serial beat
- s_last  in  1  final beat of packet; closes current word
- m_valid  out  1  output word valid
- m_ready  in  1  output word consumed when m_valid&m_ready
- m_data  out  DATA_WIDTH x PARL_MAX (unpacked array)  parallel word
- m_count  out  CNT_W  number of filled lanes in m_data
- m_last  out  1  word closed by s_last
- err_cfg  out  1  one-cycle pulse: illegal cfg_ratio sampled

Behaviour:
- Reset: single clock, synchronous active-high rst. While rst=1 and on the first edge after release: m_valid=0, m_data all '0, m_count=0, m_last=0, err_cfg=0, s_ready=0, accumulator cleared. s_ready rises one cycle after rst falls. Reset mid-word discards partial data; no word is emitted.
- Config sampling:
  - cfg_ratio/cfg_dir are latched into ratio_q/dir_q on the accepting edge of the first beat of each word. They are constant for the rest of that word.
  - cfg_ratio=0 or >PARL_MAX: ratio_q=PARL_MAX, err_cfg=1 for one cycle.
  - ratio 1 is legal: every beat is a word.
- Accumulator FSM (shared enum):
  - ACC_IDLE: cnt=0, no data held.
  - ACC_FILL: 0<cnt<ratio_q.
  - ACC_FULL: word complete but output slot occupied.
- Lane placement for beat k (0-based within word): dir_q=0 -> lane k; dir_q=1 -> lane ratio_q-1-k. Lanes >= ratio_q are always '0.
- Completion occurs on the accepting edge where cnt+1==ratio_q or s_last=1:
  - Output slot empty, or draining in the same cycle (m_valid&m_ready): word moves to the slot on that edge; m_valid=1 next cycle (1-cycle latency from last beat to m_valid); accumulator returns to ACC_IDLE.
  - Otherwise: ACC_FULL, s_ready=0 until the slot frees; transfer happens on the edge where m_ready&m_valid.
- Partial word (s_last with cnt+1<ratio_q): unfilled lanes '0, m_count=cnt+1, m_last=1. Full word: m_count=ratio_q, m_last=s_last.
- s_ready = !rst_q && (acc_state!=ACC_FULL). Combinational from registered state only; no path from m_ready.
- Output hold: m_data/m_count/m_last stable while m_valid&!m_ready. m_valid never drops without a handshake.
- Throughput: with m_ready=1 continuously, one beat accepted per cycle and one word per ratio_q cycles, with no bubbles.
- s_valid=0 mid-word: cnt holds; there is no timeout.

Decomposition:
- deser_pkg: acc_state_e enum {ACC_IDLE, ACC_FILL, ACC_FULL}; function lane_idx(k, ratio, dir); CNT_W helper function.
- Sub-module deser_out_slot: a one-entry output register with valid/ready hold, load from the accumulator, and clear on reset. The top holds the FSM, counter, config latch and accumulator array.

Test Plan:
- DATA_WIDTH=8, PARL_MAX=8, cfg_ratio=4, dir=0, beats 0x11,0x22,0x33,0x44 back-to-back, m_ready=1 -> m_data[0..3]=11,22,33,44, lanes 4..7=0, m_count=4, m_valid one cycle after 0x44 accepted.
- Same with dir=1 -> m_data[3..0]=11,22,33,44.
- ratio=4, beats 0xA1,0xA2 with s_last on 0xA2 -> m_data[0]=A1, m_data[1]=A2, others 0, m_count=2, m_last=1.
- ratio=2, m_ready=0 for 10 cycles, 6 beats offered -> 4 beats accepted (one word in slot, one in ACC_FULL), s_ready=0. Release m_ready -> both words delivered in order, none lost.
- cfg_ratio=0 then 9 -> err_cfg pulse each time, words of 8 beats.
- Assert rst after 3 of 4 beats -> no word emitted. Next 4 beats form a clean word; s_ready=0 during rst.
